// File: rtl/rc4_stream_core.sv
// rc4_stream_core: streaming RC4 cipher core; define RC4_DROP_EN to discard DROP_BYTES keystream bytes after KSA
module rc4_stream_core #(
  parameter int MAX_KEY_BYTES = 32,
  parameter int DROP_BYTES = 768
) (
  input  logic       CLK_IN,
  input  logic       RESET_IN,
  input  logic       START_IN,
  input  logic       STOP_IN,
  input  logic [7:0] KEY_SIZE_IN,
  input  logic [7:0] KEY_BYTE_IN,
  input  logic       KEY_VALID_IN,
  output logic       KEY_READY_OUT,
  input  logic [7:0] DIN_BYTE_IN,
  input  logic       DIN_VALID_IN,
  output logic       DIN_READY_OUT,
  output logic [7:0] DOUT_BYTE_OUT,
  output logic       DOUT_VALID_OUT,
  input  logic       DOUT_READY_IN,
  output logic       BUSY_OUT,
  output logic       KEY_ERR_OUT
);
  localparam int KW = MAX_KEY_BYTES > 1 ? $clog2(MAX_KEY_BYTES) : 1;
  localparam logic [7:0] MAXK = 8'(MAX_KEY_BYTES);
  if (MAX_KEY_BYTES < 1 || MAX_KEY_BYTES > 255 || DROP_BYTES > 65535) begin : g_bad_cfg
    $error("rc4_stream_core: parameter out of range");
  end
`ifdef RC4_DROP_EN
  typedef enum logic [2:0] {IDLE, INIT, KEY_LOAD, KSA, DROP, PRGA} state_t;
  logic [15:0] drop_q, drop_d;
`else
  typedef enum logic [2:0] {IDLE, INIT, KEY_LOAD, KSA, PRGA} state_t;
`endif
  state_t state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d, size_q, size_d, dout_q, dout_d;
  logic err_q, err_d, dv_q, dv_d;
  logic [7:0] s_q [256];
  logic [7:0] key_q [MAX_KEY_BYTES];
  logic [7:0] kb, ii, si, jn, sj, t, ks;
  logic size_ok, can_start, din_rdy, swap, init_we, key_we;
  assign kb = key_q[k_q[KW-1:0]];
  assign ii = state_q == KSA ? i_q : i_q + 8'd1;
  assign si = s_q[ii];
  assign jn = j_q + si + (state_q == KSA ? kb : 8'd0);
  assign sj = s_q[jn];
  assign t = si + sj;
  assign ks = t == ii ? sj : t == jn ? si : s_q[t];
  assign size_ok = KEY_SIZE_IN != 8'd0 && KEY_SIZE_IN <= MAXK;
  assign can_start = !(state_q inside {INIT, KEY_LOAD, KSA});
  assign din_rdy = state_q == PRGA && (!dv_q || DOUT_READY_IN);
  assign KEY_READY_OUT = state_q == KEY_LOAD;
  assign DIN_READY_OUT = din_rdy;
  assign DOUT_BYTE_OUT = dout_q;
  assign DOUT_VALID_OUT = dv_q;
  assign BUSY_OUT = state_q != IDLE;
  assign KEY_ERR_OUT = err_q;
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    size_d = size_q;
    err_d = err_q;
    dv_d = dv_q;
    dout_d = dout_q;
    swap = 1'b0;
    init_we = 1'b0;
    key_we = 1'b0;
`ifdef RC4_DROP_EN
    drop_d = drop_q;
`endif
    if (STOP_IN) begin
      state_d = IDLE;
      i_d = '0;
      j_d = '0;
      k_d = '0;
      dv_d = 1'b0;
      dout_d = '0;
    end else if (START_IN && can_start) begin
      state_d = size_ok ? INIT : IDLE;
      size_d = size_ok ? KEY_SIZE_IN : size_q;
      err_d = !size_ok;
      i_d = '0;
      j_d = '0;
      k_d = '0;
      dv_d = 1'b0;
      dout_d = '0;
    end else begin
      case (state_q)
        INIT: begin
          init_we = 1'b1;
          k_d = k_q + 8'd1;
          state_d = k_q == 8'd255 ? KEY_LOAD : INIT;
        end
        KEY_LOAD: if (KEY_VALID_IN) begin
          key_we = 1'b1;
          k_d = k_q == size_q - 8'd1 ? 8'd0 : k_q + 8'd1;
          state_d = k_q == size_q - 8'd1 ? KSA : KEY_LOAD;
        end
        KSA: begin
          swap = 1'b1;
          i_d = i_q + 8'd1;
          j_d = i_q == 8'd255 ? 8'd0 : jn;
          k_d = k_q == size_q - 8'd1 ? 8'd0 : k_q + 8'd1;
          if (i_q == 8'd255) begin
`ifdef RC4_DROP_EN
            state_d = DROP_BYTES > 0 ? DROP : PRGA;
            drop_d = '0;
`else
            state_d = PRGA;
`endif
          end
        end
`ifdef RC4_DROP_EN
        DROP: begin
          swap = 1'b1;
          i_d = ii;
          j_d = jn;
          drop_d = drop_q + 16'd1;
          state_d = drop_q == 16'(DROP_BYTES - 1) ? PRGA : DROP;
        end
`endif
        PRGA: begin
          dv_d = DOUT_READY_IN ? 1'b0 : dv_q;
          if (DIN_VALID_IN && din_rdy) begin
            swap = 1'b1;
            i_d = ii;
            j_d = jn;
            dv_d = 1'b1;
            dout_d = DIN_BYTE_IN ^ ks;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      size_q <= '0;
      err_q <= 1'b0;
      dv_q <= 1'b0;
      dout_q <= '0;
      for (int m = 0; m < MAX_KEY_BYTES; m++) key_q[m] <= '0;
`ifdef RC4_DROP_EN
      drop_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      size_q <= size_d;
      err_q <= err_d;
      dv_q <= dv_d;
      dout_q <= dout_d;
`ifdef RC4_DROP_EN
      drop_q <= drop_d;
`endif
      if (init_we) s_q[k_q] <= k_q;
      if (swap) begin
        s_q[ii] <= sj;
        s_q[jn] <= si;
      end
      if (key_we) key_q[k_q[KW-1:0]] <= KEY_BYTE_IN;
    end
  end
endmodule
